// File: rtl/fft_out_unpack.sv
// fft_out_unpack: unpacks two-bin FFT result beats into a one-bin-per-beat
// AXI-Stream. It adds frame delimiting (tlast) and a completed-frame counter.
module fft_out_unpack #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [DATA_WIDTH*4-1:0] s_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH*2-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic [15:0]             frame_cnt,
    output logic                    busy
);

    localparam int BIN_W = DATA_WIDTH * 2;
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_HI,
        ST_LO
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [DATA_WIDTH*4-1:0] hold_q;
    logic [CNT_W-1:0]        bin_cnt_q;
    logic [15:0]             frame_cnt_q;
    logic                    in_hs;
    logic                    out_hs;

    // A new beat is taken only when nothing is held, or in the same cycle
    // the held bin_b leaves, so the holding register never overflows.
    assign s_axis_tready = !reset && ((state_q == ST_EMPTY) ||
                                      ((state_q == ST_LO) && m_axis_tready));
    assign m_axis_tvalid = (state_q != ST_EMPTY);
    assign m_axis_tdata  = (state_q == ST_LO) ? hold_q[BIN_W-1:0]
                                              : hold_q[2*BIN_W-1:BIN_W];
    assign m_axis_tlast  = m_axis_tvalid && (bin_cnt_q == LAST_BIN);
    assign frame_cnt     = frame_cnt_q;
    assign busy          = (state_q != ST_EMPTY) || (bin_cnt_q != '0);

    assign in_hs  = s_axis_tvalid && s_axis_tready;
    assign out_hs = m_axis_tvalid && m_axis_tready;

    // Next-state: walk bin_a then bin_b of the held beat, chaining straight
    // into the next beat when one arrives as bin_b leaves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_hs) begin
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (out_hs) begin
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (out_hs) begin
                    state_d = in_hs ? ST_HI : ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Holding register captures the whole input beat on each accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else if (in_hs) begin
            hold_q <= s_axis_tdata;
        end
    end

    // Bin position within the current frame, advanced per emitted bin.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_cnt_q <= '0;
        end else if (out_hs) begin
            if (bin_cnt_q == LAST_BIN) begin
                bin_cnt_q <= '0;
            end else begin
                bin_cnt_q <= bin_cnt_q + 1'b1;
            end
        end
    end

    // Completed-frame counter, bumped when the tlast bin is accepted; wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (out_hs && m_axis_tlast) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_fft_out_unpack.sv
// Testbench for fft_out_unpack: table-driven single beats, hand-written
// backpressure and reset sequences, and randomized streams against a queue model.
module tb_fft_out_unpack;

    localparam int DW = 8;
    localparam int FL = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW*4-1:0] s_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW*2-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic [15:0]   frame_cnt;
    logic          busy;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model: expected bins in order, global bin index since the
    // last reset, and the number of frames completed so far.
    logic [15:0] exp_q[$];
    int          out_idx;
    int          exp_frames;

    typedef struct {
        logic [31:0] data;
        logic [15:0] hi;
        logic [15:0] lo;
    } beat_vec_t;

    beat_vec_t vecs[4];

    fft_out_unpack #(
        .DATA_WIDTH(DW),
        .FRAME_LEN (FL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .frame_cnt    (frame_cnt),
        .busy         (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Safety net so a stuck run still terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic record_fail(input string name);
        checks_total++;
        $display("[TB] FAIL %s: got event expected none", name);
    endtask

    task automatic apply_stimulus(input logic tv, input logic [31:0] td, input logic tr);
        s_axis_tvalid = tv;
        s_axis_tdata  = td;
        m_axis_tready = tr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        out_idx    = 0;
        exp_frames = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply_stimulus(1'b0, 32'h0, 1'b0);
        tick();
        tick();
        #1;
        check_output("tready_in_reset", s_axis_tready, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        check_output("rst_tready", s_axis_tready, 1'b1);
        check_output("rst_tvalid", m_axis_tvalid, 1'b0);
        check_output("rst_tdata", m_axis_tdata, 16'h0);
        check_output("rst_tlast", m_axis_tlast, 1'b0);
        check_output("rst_frame_cnt", frame_cnt, 16'h0);
        check_output("rst_busy", busy, 1'b0);
        model_clear();
    endtask

    // Streams n_beats of incrementing bin values and checks every emitted
    // bin against the model; optionally requires a gap-free output run.
    task automatic run_stream(input int n_beats, input int valid_pct, input int ready_pct,
                              input int budget, input bit gapless, input logic [15:0] base);
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        bit          offering = 0;
        bit          started = 0;
        bit          prev_stall = 0;
        logic [31:0] cur = '0;
        logic [15:0] prev_data = '0;
        logic        prev_last = 1'b0;
        logic [15:0] e;
        while (got < 2 * n_beats && cyc < budget) begin
            if (!offering && sent < n_beats && $urandom_range(99) < valid_pct) begin
                offering = 1;
                cur = {base + 16'(2 * sent), base + 16'(2 * sent + 1)};
            end
            apply_stimulus(offering, offering ? cur : 32'h0,
                           ($urandom_range(99) < ready_pct));
            #1;
            if (prev_stall) begin
                check_output("stall_tvalid", m_axis_tvalid, 1'b1);
                check_output("stall_tdata", m_axis_tdata, prev_data);
                check_output("stall_tlast", m_axis_tlast, prev_last);
            end
            if (gapless && started) begin
                check_output("no_bubble", m_axis_tvalid, 1'b1);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    record_fail("spurious_output");
                end else begin
                    e = exp_q.pop_front();
                    check_output("bin_data", m_axis_tdata, e);
                end
                check_output("bin_tlast", m_axis_tlast, (out_idx % FL) == FL - 1);
                check_output("frame_cnt_run", frame_cnt, 16'(exp_frames));
                if ((out_idx % FL) == FL - 1) begin
                    exp_frames++;
                end
                out_idx++;
                got++;
                started = 1;
            end
            if (s_axis_tvalid && s_axis_tready) begin
                exp_q.push_back(cur[31:16]);
                exp_q.push_back(cur[15:0]);
                sent++;
                offering = 0;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            tick();
            cyc++;
        end
        if (got < 2 * n_beats) begin
            record_fail("stream_budget");
        end
        apply_stimulus(1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        int hs;
        vecs[0] = '{data: 32'h1234ABCD, hi: 16'h1234, lo: 16'hABCD};
        vecs[1] = '{data: 32'hFFFF0000, hi: 16'hFFFF, lo: 16'h0000};
        vecs[2] = '{data: 32'h00017FFF, hi: 16'h0001, lo: 16'h7FFF};
        vecs[3] = '{data: 32'h80008001, hi: 16'h8000, lo: 16'h8001};

        reset = 1'b1;
        apply_stimulus(1'b0, 32'h0, 1'b0);
        do_reset();

        // Single beats from the table with downstream always ready.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, vecs[i].data, 1'b1);
            #1;
            check_output("vec_accept", s_axis_tready, 1'b1);
            tick();
            apply_stimulus(1'b0, 32'h0, 1'b1);
            #1;
            check_output("vec_hi_valid", m_axis_tvalid, 1'b1);
            check_output("vec_hi", m_axis_tdata, vecs[i].hi);
            check_output("vec_hi_tlast", m_axis_tlast, 1'b0);
            tick();
            check_output("vec_lo_valid", m_axis_tvalid, 1'b1);
            check_output("vec_lo", m_axis_tdata, vecs[i].lo);
            check_output("vec_lo_tlast", m_axis_tlast, 1'b0);
            tick();
            check_output("vec_idle_valid", m_axis_tvalid, 1'b0);
            check_output("vec_idle_busy", busy, 1'b1);
            check_output("vec_idle_tlast", m_axis_tlast, 1'b0);
        end

        // Full frame, back-to-back, no output gaps, tlast on bin 16.
        do_reset();
        run_stream(8, 100, 100, 100, 1'b1, 16'h0200);
        tick();
        check_output("frame_cnt_after_frame", frame_cnt, 16'd1);
        check_output("busy_after_frame", busy, 1'b0);

        // Backpressure while bin_a is presented, with a second beat waiting.
        do_reset();
        apply_stimulus(1'b1, 32'hCAFE1234, 1'b0);
        tick();
        apply_stimulus(1'b1, 32'h55667788, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            check_output("bp_hold_data", m_axis_tdata, 16'hCAFE);
            check_output("bp_no_accept", s_axis_tready, 1'b0);
            tick();
        end
        m_axis_tready = 1'b1;
        #1;
        check_output("bp_release_hi", m_axis_tdata, 16'hCAFE);
        check_output("bp_release_no_accept", s_axis_tready, 1'b0);
        tick();
        check_output("bp_lo", m_axis_tdata, 16'h1234);
        check_output("bp_lo_accept", s_axis_tready, 1'b1);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b1);
        #1;
        check_output("bp_next_hi", m_axis_tdata, 16'h5566);
        tick();
        check_output("bp_next_lo", m_axis_tdata, 16'h7788);
        tick();
        check_output("bp_drained", m_axis_tvalid, 1'b0);

        // Reset while bin_b of the third beat is presented (after 5 bins).
        do_reset();
        hs = 0;
        for (int c = 0; c < 30 && hs < 5; c++) begin
            apply_stimulus(1'b1, 32'h11112222, 1'b1);
            #1;
            if (m_axis_tvalid && m_axis_tready) begin
                hs++;
            end
            tick();
        end
        if (hs < 5) begin
            record_fail("midframe_budget");
        end
        apply_stimulus(1'b0, 32'h0, 1'b0);
        #1;
        check_output("midframe_lo_valid", m_axis_tvalid, 1'b1);
        check_output("midframe_lo_data", m_axis_tdata, 16'h2222);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_output("midrst_tvalid", m_axis_tvalid, 1'b0);
        check_output("midrst_frame_cnt", frame_cnt, 16'h0);
        check_output("midrst_busy", busy, 1'b0);
        model_clear();
        run_stream(8, 100, 100, 100, 1'b1, 16'h0300);
        tick();
        check_output("midrst_frame_after", frame_cnt, 16'd1);

        // Randomized handshakes over 1000 beats of incrementing data.
        do_reset();
        run_stream(1000, 70, 60, 20000, 1'b0, 16'h0000);
        tick();
        check_output("random_frame_cnt", frame_cnt, 16'd125);
        check_output("random_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
